// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: snoops a CPU write to the DMA register, halts the CPU and copies one page
// into OAMDATA. Define OAM_DMA_PARITY_ALIGN_EN to add the odd-cycle ALIGN dummy read.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  input  logic [7:0]  r_data,
  output logic        dma_active,
  output logic        cpu_halt,
  output logic [15:0] dma_addr,
  output logic        dma_r_en,
  output logic [7:0]  dma_w_data,
  output logic        dma_done
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
`ifdef OAM_DMA_PARITY_ALIGN_EN
    StAlign,
`endif
    StRead,
    StWrite
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       done_q, done_d;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic odd_q;

  // Tracks CPU get/put parity so the first read lands on the right half-cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      odd_q <= 1'b0;
    end else if (clock_en) begin
      odd_q <= ~odd_q;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      page_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    done_d  = done_q;
    if (clock_en) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_addr == DMA_REG_ADDR && !cpu_r_en) begin
            page_d  = cpu_w_data;
            idx_d   = '0;
            state_d = StHalt;
          end
        end
        StHalt: begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
          state_d = odd_q ? StAlign : StRead;
`else
          state_d = StRead;
`endif
        end
`ifdef OAM_DMA_PARITY_ALIGN_EN
        StAlign: state_d = StRead;
`endif
        StRead:  state_d = StWrite;
        StWrite: begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StRead;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Dummy cycles read $0000 so no register with read side effects is touched.
  always_comb begin
    dma_addr   = '0;
    dma_r_en   = 1'b1;
    dma_w_data = '0;
    unique case (state_q)
      StRead: dma_addr = {page_q, idx_q};
      StWrite: begin
        dma_addr   = OAM_DATA_ADDR;
        dma_r_en   = 1'b0;
        dma_w_data = r_data;
      end
      default: ;
    endcase
  end

  assign dma_active = (state_q != StIdle);
  assign cpu_halt   = (state_q != StIdle);
  assign dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: trigger-decode table, directed transfers and randomized
// transfers checked against a per-cycle bus schedule derived from the transfer rules.
module tb_oam_dma_ctrl;

  localparam int XferLen = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_en;
  logic [15:0] cpu_addr;
  logic        cpu_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  r_data;
  logic        dma_active;
  logic        cpu_halt;
  logic [15:0] dma_addr;
  logic        dma_r_en;
  logic [7:0]  dma_w_data;
  logic        dma_done;

  oam_dma_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .clock_en   (clock_en),
    .cpu_addr   (cpu_addr),
    .cpu_r_en   (cpu_r_en),
    .cpu_w_data (cpu_w_data),
    .r_data     (r_data),
    .dma_active (dma_active),
    .cpu_halt   (cpu_halt),
    .dma_addr   (dma_addr),
    .dma_r_en   (dma_r_en),
    .dma_w_data (dma_w_data),
    .dma_done   (dma_done)
  );

  always #5 clock = ~clock;

  // cpu_memory model: registered read of the muxed bus address.
  logic [7:0]  mem [0:65535];
  logic [15:0] bus_addr;
  logic        bus_r_en;
  assign bus_addr = dma_active ? dma_addr : cpu_addr;
  assign bus_r_en = dma_active ? dma_r_en : cpu_r_en;
  always @(posedge clock) begin
    if (clock_en && bus_r_en) r_data <= mem[bus_addr];
  end

  int total = 0;
  int bad   = 0;
  bit odd_m = 1'b0;
  bit align_en;

  typedef struct {
    logic [15:0] addr;
    logic        r_en;
    logic        ce;
    logic        trig;
  } trig_vec_t;

  trig_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cpu_idle();
    cpu_addr   = 16'($urandom_range(0, 16'h3fff));
    cpu_r_en   = 1'b1;
    cpu_w_data = 8'($urandom);
  endtask

  // One clock; the model's parity bit counts enabled edges since reset.
  task automatic cycle(input bit ce, input bit rst);
    reset    = rst;
    clock_en = ce;
    @(posedge clock);
    #1;
    if (rst) odd_m = 1'b0;
    else if (ce) odd_m = ~odd_m;
    reset = 1'b0;
  endtask

  task automatic align_to(input bit want);
    int guard = 0;
    while (odd_m != want && guard < 4) begin
      cpu_idle();
      cycle(1'b1, 1'b0);
      guard++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_active"}, dma_active, 1'b0);
    check({tag, "_halt"}, cpu_halt, 1'b0);
    check({tag, "_addr"}, dma_addr, 16'h0000);
    check({tag, "_r_en"}, dma_r_en, 1'b1);
  endtask

  task automatic do_xfer(input logic [7:0] page, input int gap_pct, input int stall_at,
                         input int abort_idx);
    bit          aln;
    int          n_ent;
    int          e;
    int          cyc;
    int          stall;
    int          halt_cnt;
    int          off;
    int          bi;
    logic [7:0]  b8;
    logic [15:0] ea;
    bit          er;
    bit          wr;
    bit          ce;
    cpu_addr   = 16'h4014;
    cpu_r_en   = 1'b0;
    cpu_w_data = page;
    cycle(1'b1, 1'b0);
    check("trig_halt", cpu_halt, 1'b1);
    aln      = align_en & odd_m;
    n_ent    = 1 + int'(aln) + 2 * XferLen;
    e        = 0;
    cyc      = 0;
    stall    = 0;
    halt_cnt = 0;
    while (e < n_ent && cyc < 4000) begin
      cyc++;
      if (e < 1 + int'(aln)) begin
        ea = 16'h0000; er = 1'b1; wr = 1'b0; bi = 0;
      end else begin
        off = e - 1 - int'(aln);
        bi  = off / 2;
        b8  = bi[7:0];
        if (off % 2 == 0) begin
          ea = {page, b8}; er = 1'b1; wr = 1'b0;
        end else begin
          ea = 16'h2004; er = 1'b0; wr = 1'b1;
        end
      end
      b8 = bi[7:0];
      check("xfer_active", dma_active, 1'b1);
      check("xfer_halt", cpu_halt, 1'b1);
      check("xfer_addr", dma_addr, ea);
      check("xfer_r_en", dma_r_en, er);
      if (wr) check("xfer_wdata", dma_w_data, mem[{page, b8}]);
      if (wr && bi == abort_idx) begin
        cpu_idle();
        cycle(1'b1, 1'b1);
        check_idle_outputs("abort");
        check("abort_done", dma_done, 1'b0);
        check("abort_wdata", dma_w_data, 8'h00);
        cpu_idle();
        cycle(1'b1, 1'b0);
        check("abort_done_next", dma_done, 1'b0);
        check("abort_halt_next", cpu_halt, 1'b0);
        return;
      end
      if (e == stall_at && stall < 5) begin
        ce = 1'b0;
        stall++;
      end else begin
        ce = ($urandom_range(0, 99) >= gap_pct);
      end
      if ($urandom_range(0, 7) == 0) begin
        cpu_addr   = 16'h4014;
        cpu_r_en   = 1'b0;
        cpu_w_data = 8'($urandom);
      end else begin
        cpu_idle();
      end
      if (ce && cpu_halt) halt_cnt++;
      cycle(ce, 1'b0);
      if (ce) e++;
    end
    if (e < n_ent) check("xfer_timeout", e, n_ent);
    check("halt_len", halt_cnt, 1 + int'(aln) + 2 * XferLen);
    check("end_done", dma_done, 1'b1);
    check_idle_outputs("end");
  endtask

  task automatic done_clears();
    cpu_idle();
    cycle(1'b0, 1'b0);
    check("done_hold", dma_done, 1'b1);
    cpu_idle();
    cycle(1'b1, 1'b0);
    check("done_clear", dma_done, 1'b0);
    check("done_clear_halt", cpu_halt, 1'b0);
  endtask

  initial begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);

    cpu_idle();
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check_idle_outputs("reset");
    check("reset_wdata", dma_w_data, 8'h00);
    check("reset_done", dma_done, 1'b0);

    vecs[0] = '{addr: 16'h4014, r_en: 1'b0, ce: 1'b1, trig: 1'b1};
    vecs[1] = '{addr: 16'h4014, r_en: 1'b1, ce: 1'b1, trig: 1'b0};
    vecs[2] = '{addr: 16'h4015, r_en: 1'b0, ce: 1'b1, trig: 1'b0};
    vecs[3] = '{addr: 16'h4013, r_en: 1'b0, ce: 1'b1, trig: 1'b0};
    vecs[4] = '{addr: 16'h0014, r_en: 1'b0, ce: 1'b1, trig: 1'b0};
    vecs[5] = '{addr: 16'h4014, r_en: 1'b0, ce: 1'b0, trig: 1'b0};
    vecs[6] = '{addr: 16'hc014, r_en: 1'b0, ce: 1'b1, trig: 1'b0};
    vecs[7] = '{addr: 16'h4014, r_en: 1'b0, ce: 1'b1, trig: 1'b1};
    for (int v = 0; v < 8; v++) begin
      cpu_idle();
      cycle(1'b1, 1'b1);
      cpu_addr   = vecs[v].addr;
      cpu_r_en   = vecs[v].r_en;
      cpu_w_data = 8'($urandom);
      cycle(vecs[v].ce, 1'b0);
      check($sformatf("vec%0d_halt", v), cpu_halt, vecs[v].trig);
      check($sformatf("vec%0d_active", v), dma_active, vecs[v].trig);
      check($sformatf("vec%0d_addr", v), dma_addr, 16'h0000);
    end
    cpu_idle();
    cycle(1'b1, 1'b1);

    // HALT on parity 0, then HALT on parity 1.
    align_to(1'b1);
    do_xfer(8'h02, 0, -1, -1);
    done_clears();
    align_to(1'b0);
    do_xfer(8'h02, 0, -1, -1);
    done_clears();

    // Five-cycle clock_en stall mid-transfer, then a back-to-back trigger on the done cycle.
    do_xfer(8'h02, 0, 50, -1);
    do_xfer(8'h20, 0, -1, -1);
    done_clears();

    // Reset while writing byte 100.
    do_xfer(8'h02, 0, -1, 100);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        cpu_idle();
        cycle(1'b1, 1'b0);
      end
      do_xfer(8'($urandom), 20, -1, -1);
      done_clears();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA engine, triggered by a CPU write to $4014.
- Snoops the CPU bus for that write, then halts the CPU and takes over the cpu_memory address/data/r_en inputs through an external mux.
- Copies 256 bytes from CPU page $XX00-$XXFF into PPU OAMDATA ($2004), one byte per read/write cycle pair.
- Sits between the CPU core/mem_inputs and cpu_memory; releases the bus when the copy completes.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written each byte.
- XFER_LEN, 256, bytes per transfer. Legal values are 1..256; the byte index is 8 bits.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clock_en  in  1  CPU-rate enable; all state advances only when high
- cpu_addr  in  16  CPU-driven address (mem_inputs addr)
- cpu_r_en  in  1  CPU read enable (1 read, 0 write)
- cpu_w_data  in  8  CPU write data; page number on trigger
- r_data  in  8  cpu_memory r_data (registered read result)
- dma_active  out  1  bus mux select; 1 = DMA drives cpu_memory
- cpu_halt  out  1  stalls the CPU state machine
- dma_addr  out  16  address to cpu_memory while dma_active
- dma_r_en  out  1  read enable to cpu_memory while dma_active
- dma_w_data  out  8  write data to cpu_memory while dma_active
- dma_done  out  1  one-cycle pulse after the last byte is written

Behaviour:
- Reset values: state IDLE, page=0, idx=0, odd_cycle=0.
- Reset values of outputs: dma_active=0, cpu_halt=0, dma_addr=0, dma_r_en=1, dma_w_data=0, dma_done=0.
- Reset asserted mid-transfer aborts to IDLE on that edge. Bytes already written stay in OAM.
- odd_cycle toggles on every clock_en edge.
- Nothing changes on edges where clock_en=0, including odd_cycle and dma_done.
- Trigger: IDLE, clock_en=1, cpu_addr==DMA_REG_ADDR, cpu_r_en=0. On that edge, page<=cpu_w_data, idx<=0, state<=HALT.
- Reads of DMA_REG_ADDR never trigger. Writes to any other address never trigger.
- Writes to DMA_REG_ADDR outside IDLE are ignored.
- cpu_halt = (state != IDLE). dma_active = (state != IDLE).
- States and transitions:
  - IDLE: outputs at their reset values.
  - HALT: dummy read, addr 16'h0000, r_en=1. Next state is ALIGN if odd_cycle==1 (see Optional Feature), else READ.
  - ALIGN: dummy read of 16'h0000; next state READ.
  - READ: addr={page,idx}, r_en=1; next state WRITE.
  - WRITE: addr=OAM_DATA_ADDR, r_en=0, dma_w_data=r_data (combinational pass-through of the byte read in the previous cycle).
    - If idx==XFER_LEN-1: next state IDLE, dma_done=1 for one clock_en cycle.
    - Otherwise: idx<=idx+1, next state READ.
- Dummy addresses are fixed at $0000 so that PPU/IO registers with read side effects are never touched.
- Source page $20-$3F is legal. r_data then carries PPU register data; no special case.
- idx is 8 bits. With XFER_LEN=256, idx wraps 255->0 exactly on the WRITE->IDLE transition.
- Halt duration, counted from the first HALT cycle to the last WRITE cycle inclusive: 1 + (ALIGN ? 1 : 0) + 2*XFER_LEN clock_en cycles. For XFER_LEN=256 this is 513 or 514.
- dma_done is the cycle after the last WRITE; at that point cpu_halt=0.
- A new trigger is accepted in the same cycle dma_done is high.

Optional Feature:
- Macro: OAM_DMA_PARITY_ALIGN_EN.
- Defined: the HALT->ALIGN path is taken when odd_cycle==1 at HALT, matching 2A03 get/put alignment. Halt lasts 513 cycles on even starts, 514 on odd starts.
- Not defined: the ALIGN state and odd_cycle logic are compiled out. HALT always goes to READ; halt is always 1+2*XFER_LEN cycles.

Test Plan:
- RAM $0200-$02FF preloaded with value i at offset i; CPU writes $02 to $4014 on an even cycle.
  - dma_addr alternates $0200,$2004,$0201,$2004,...
  - dma_w_data sequence is 00..FF.
  - cpu_halt high exactly 513 cycles; dma_done pulses once.
- Same transfer started on an odd cycle with OAM_DMA_PARITY_ALIGN_EN defined -> one extra dummy read of $0000; cpu_halt high 514 cycles.
- Odd-cycle start with the macro undefined -> 513 cycles, no ALIGN state visited.
- CPU read of $4014, CPU write of $4015, and CPU write of $4014 during an active transfer -> no new trigger; page and idx unchanged.
- reset pulsed during WRITE with idx=100 -> next cycle state IDLE, cpu_halt=0, dma_active=0, no dma_done.
- clock_en held low for 5 cycles mid-transfer -> dma_addr and idx frozen; total halt still 513 clock_en cycles.
